// File: rtl/dm_pkg.sv
// dm_pkg: shared constants for the data-memory arbiter.
//   DMOP_*        memory operation encodings (none/word/half/byte)
//   arb_state_t   arbiter FSM states
//   is_misaligned helper used by the optional alignment check
package dm_pkg;

  localparam logic [2:0] DMOP_NONE = 3'd0;
  localparam logic [2:0] DMOP_WORD = 3'd1;
  localparam logic [2:0] DMOP_HALF = 3'd2;
  localparam logic [2:0] DMOP_BYTE = 3'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_t;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lsb);
    return ((op == DMOP_WORD) && (lsb != 2'b00)) || ((op == DMOP_HALF) && lsb[0]);
  endfunction

endpackage

// File: rtl/dm_arb_prio.sv
// dm_arb_prio: winner select for the two-port data-memory arbiter plus the
// port-1 starvation counter.
//   clk, reset   clock / synchronous active-high reset
//   idle         arbiter is in IDLE this cycle (counter only moves then)
//   p0_req       port 0 request
//   p1_req       port 1 request
//   win_p1       1 = port 1 wins this cycle, 0 = port 0 wins
module dm_arb_prio #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic p0_req,
  input  logic p1_req,
  output logic win_p1
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  // Port 0 normally wins; port 1 takes over once it has lost MAX_WAIT times
  // in a row, or whenever port 0 is not asking.
  assign win_p1 = p1_req && ((wait_cnt == MAX_WAIT_C) || !p0_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (idle) begin
      if (!p1_req || win_p1) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != MAX_WAIT_C) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester arbiter/sequencer in front of the single-port
// data memory. Each granted request occupies exactly one memory cycle.
//   clk, reset                         clock / synchronous active-high reset
//   p0_* / p1_*  req,we,op,addr,wdata,pc  requester inputs (port 0 = CPU)
//   p0_gnt, p1_gnt                     one-cycle pulse: request captured
//   p0_rvalid, p1_rvalid               one-cycle pulse: rdata/err valid
//   rdata, err                         registered load result / misalign flag
//   busy                               FSM not in IDLE
//   dm_addr, dm_wdata, dm_we, dm_op, dm_pc, dm_rdata   memory interface
// Optional macro DM_ARB_ALIGN_CHK_EN: suppresses misaligned word/half
// accesses and reports them through err.
//
// state     | meaning
// ST_IDLE   | waiting for a request; captures the winner at posedge
// ST_ACCESS | memory cycle for the latched request; result at closing edge
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [2:0]        p0_op,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [31:0]       p0_pc,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [2:0]        p1_op,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [31:0]       p1_pc,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic [2:0]        dm_op,
  output logic [31:0]       dm_pc,
  input  logic [DATA_W-1:0] dm_rdata
);

  arb_state_t        state;
  logic              lat_port;
  logic              lat_we;
  logic [2:0]        lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [31:0]       lat_pc;
  logic              win_p1;
  logic              acc_bad;

  dm_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk    (clk),
    .reset  (reset),
    .idle   (state == ST_IDLE),
    .p0_req (p0_req),
    .p1_req (p1_req),
    .win_p1 (win_p1)
  );

`ifdef DM_ARB_ALIGN_CHK_EN
  assign acc_bad = is_misaligned(lat_op, lat_addr[1:0]);
`else
  assign acc_bad = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  // Memory bus is quiet outside ACCESS. dm_we is also gated by reset so an
  // access aborted by reset never writes.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_pc    = '0;
    dm_op    = DMOP_NONE;
    dm_we    = 1'b0;
    if (state == ST_ACCESS) begin
      dm_addr  = lat_addr;
      dm_wdata = lat_wdata;
      dm_pc    = lat_pc;
      dm_op    = acc_bad ? DMOP_NONE : lat_op;
      dm_we    = lat_we && !reset && !acc_bad && (lat_op != DMOP_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_op    <= DMOP_NONE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_pc    <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (p0_req || p1_req) begin
            lat_port <= win_p1;
            if (win_p1) begin
              lat_we    <= p1_we;
              lat_op    <= p1_op;
              lat_addr  <= p1_addr;
              lat_wdata <= p1_wdata;
              lat_pc    <= p1_pc;
              p1_gnt    <= 1'b1;
            end else begin
              lat_we    <= p0_we;
              lat_op    <= p0_op;
              lat_addr  <= p0_addr;
              lat_wdata <= p0_wdata;
              lat_pc    <= p0_pc;
              p0_gnt    <= 1'b1;
            end
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Stores, no-op requests and rejected accesses return zero.
          if (lat_we || acc_bad || (lat_op == DMOP_NONE)) begin
            rdata <= '0;
          end else begin
            rdata <= dm_rdata;
          end
          err <= acc_bad;
          if (lat_port) begin
            p1_rvalid <= 1'b1;
          end else begin
            p0_rvalid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter with a behavioural
// word-addressed RAM (sign-extending sub-word loads) on the memory side.
module tb_dm_arbiter;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_op, p1_op;
  logic [31:0] p0_addr, p0_wdata, p0_pc, p1_addr, p1_wdata, p1_pc;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] rdata;
  logic        err, busy;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic        dm_we;
  logic [2:0]  dm_op;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_op(p0_op), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_pc(p0_pc), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_op(p1_op), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_pc(p1_pc), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .err(err), .busy(busy),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_op(dm_op),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  logic [31:0] m_word;
  logic [15:0] m_h;
  logic [7:0]  m_b;
  int          wr_cnt = 0;

  always_comb begin
    m_word   = mem[dm_addr[7:2]];
    m_h      = dm_addr[1] ? m_word[31:16] : m_word[15:0];
    m_b      = m_word[8*dm_addr[1:0] +: 8];
    dm_rdata = 32'h0;
    case (dm_op)
      DMOP_WORD: dm_rdata = m_word;
      DMOP_HALF: dm_rdata = {{16{m_h[15]}}, m_h};
      DMOP_BYTE: dm_rdata = {{24{m_b[7]}}, m_b};
      default:   dm_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (dm_we) begin
      wr_cnt <= wr_cnt + 1;
      case (dm_op)
        DMOP_WORD: mem[dm_addr[7:2]] <= dm_wdata;
        DMOP_HALF: mem[dm_addr[7:2]][16*dm_addr[1] +: 16] <= dm_wdata[15:0];
        DMOP_BYTE: mem[dm_addr[7:2]][8*dm_addr[1:0] +: 8] <= dm_wdata[7:0];
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk_exp(input logic port, input logic [31:0] rd, input logic e);
    exp_t x;
    x.port = port; x.rdata = rd; x.err = e;
    return x;
  endfunction

  always @(negedge clk) begin
    if (p0_rvalid || p1_rvalid) begin
      exp_t e;
      chk("rv_both", {31'd0, p0_rvalid && p1_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        chk("rv_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rv_port", {31'd0, p1_rvalid}, {31'd0, e.port});
        chk("rv_rdata", rdata, e.rdata);
        chk("rv_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic port, input logic we, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.port = port; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic clr_inputs();
    p0_req = 0; p0_we = 0; p0_op = 0; p0_addr = 0; p0_wdata = 0; p0_pc = 0;
    p1_req = 0; p1_we = 0; p1_op = 0; p1_addr = 0; p1_wdata = 0; p1_pc = 0;
  endtask

  // Single isolated access; caller is just past a negedge.
  task automatic do_access(input vec_t v, input logic [31:0] pc);
    logic got;
    logic g;
    got = 0;
    if (v.port) begin
      p1_we = v.we; p1_op = v.op; p1_addr = v.addr; p1_wdata = v.wdata; p1_pc = pc; p1_req = 1;
    end else begin
      p0_we = v.we; p0_op = v.op; p0_addr = v.addr; p0_wdata = v.wdata; p0_pc = pc; p0_req = 1;
    end
    sb.push_back(mk_exp(v.port, v.exp_rdata, v.exp_err));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = v.port ? p1_gnt : p0_gnt;
      if (g) begin
        got = 1;
        chk("gnt_latency", i, 0);
        break;
      end
    end
    chk("gnt_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("acc_busy", {31'd0, busy}, 32'd1);
      chk("acc_dm_we", {31'd0, dm_we}, {31'd0, v.we && (v.op != DMOP_NONE) && !v.exp_err});
      chk("acc_dm_op", {29'd0, dm_op}, {29'd0, v.exp_err ? DMOP_NONE : v.op});
      chk("acc_dm_addr", dm_addr, v.addr);
      chk("acc_dm_pc", dm_pc, pc);
      if (v.we) chk("acc_dm_wdata", dm_wdata, v.wdata);
      chk("acc_other_gnt", {31'd0, v.port ? p0_gnt : p1_gnt}, 32'd0);
    end
    p0_req = 0;
    p1_req = 0;
    @(negedge clk);
    chk("rv_latency", {31'd0, v.port ? p1_rvalid : p0_rvalid}, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_dm_we", {31'd0, dm_we}, 32'd0);
    @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  vec_t tbl [14];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    logic        exp_order [6];
    int          grants, ng, nr, wc;
    int          gc [3];
    int          rc [3];
    logic        mis;

    tbl[0]  = mk(0, 1, DMOP_WORD, 32'h10, 32'hDEADBEEF, 32'h0,        0);
    tbl[1]  = mk(0, 0, DMOP_WORD, 32'h10, 32'h0,        32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 1, DMOP_WORD, 32'h20, 32'h80FF1234, 32'h0,        0);
    tbl[3]  = mk(0, 0, DMOP_BYTE, 32'h23, 32'h0,        32'hFFFFFF80, 0);
    tbl[4]  = mk(0, 0, DMOP_HALF, 32'h22, 32'h0,        32'hFFFF80FF, 0);
    tbl[5]  = mk(1, 0, DMOP_BYTE, 32'h20, 32'h0,        32'h00000034, 0);
    tbl[6]  = mk(1, 1, DMOP_HALF, 32'h12, 32'h0000CAFE, 32'h0,        0);
    tbl[7]  = mk(1, 0, DMOP_WORD, 32'h10, 32'h0,        32'hCAFEBEEF, 0);
    tbl[8]  = mk(0, 1, DMOP_BYTE, 32'h11, 32'h0000005A, 32'h0,        0);
    tbl[9]  = mk(0, 0, DMOP_WORD, 32'h10, 32'h0,        32'hCAFE5AEF, 0);
    tbl[10] = mk(0, 0, DMOP_NONE, 32'h10, 32'h0,        32'h0,        0);
    tbl[11] = mk(1, 1, DMOP_NONE, 32'h10, 32'h12345678, 32'h0,        0);
    tbl[12] = mk(0, 0, DMOP_WORD, 32'h10, 32'h0,        32'hCAFE5AEF, 0);
    tbl[13] = mk(1, 0, DMOP_HALF, 32'h20, 32'h0,        32'h00001234, 0);

    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0;
    exp_order[3] = 0; exp_order[4] = 1; exp_order[5] = 0;

    // ---- reset state ----
    clr_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_dm_op", {29'd0, dm_op}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    reset = 0;
    @(negedge clk);

    // ---- table-driven single accesses ----
    for (int i = 0; i < 14; i++) begin
      do_access(tbl[i], 32'h1000 + 32'(i * 4));
    end

    // ---- simultaneous requests: starvation bound ----
    p0_we = 0; p0_op = DMOP_WORD; p0_addr = 32'h10; p0_pc = 32'h2000; p0_req = 1;
    p1_we = 0; p1_op = DMOP_WORD; p1_addr = 32'h20; p1_pc = 32'h3000; p1_req = 1;
    grants = 0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt) begin
        chk("arb_order", {31'd0, p1_gnt}, {31'd0, exp_order[grants]});
        sb.push_back(mk_exp(p1_gnt, p1_gnt ? 32'h80FF1234 : 32'hCAFE5AEF, 1'b0));
        if (grants == 3) chk("arb_wait_sat", {28'd0, dut.u_prio.wait_cnt}, 32'd4);
        if (grants == 4) chk("arb_wait_clr", {28'd0, dut.u_prio.wait_cnt}, 32'd0);
        grants++;
        if (grants == 6) begin
          p0_req = 0;
          p1_req = 0;
        end
      end
    end
    chk("arb_grants", grants, 6);
    p0_req = 0; p1_req = 0;
    repeat (3) @(negedge clk);
    chk("arb_drained", sb.size(), 0);
    sb.delete();

    // ---- back-to-back port-0 loads with req held ----
    p0_we = 0; p0_op = DMOP_WORD; p0_addr = 32'h20; p0_pc = 32'h4000; p0_req = 1;
    ng = 0; nr = 0;
    for (int c = 0; c < 30 && nr < 3; c++) begin
      @(negedge clk);
      if (p0_gnt && ng < 3) begin
        gc[ng] = c;
        sb.push_back(mk_exp(1'b0, 32'h80FF1234, 1'b0));
        ng++;
        if (ng == 3) p0_req = 0;
      end
      if (p0_rvalid && nr < 3) begin
        rc[nr] = c;
        chk("b2b_rv_idle", {31'd0, busy}, 32'd0);
        nr++;
      end
    end
    p0_req = 0;
    chk("b2b_count", nr, 3);
    if (nr == 3) begin
      chk("b2b_gap01", gc[1] - gc[0], 2);
      chk("b2b_gap12", gc[2] - gc[1], 2);
      for (int k = 0; k < 3; k++) chk("b2b_rv_lat", rc[k] - gc[k], 1);
    end
    @(negedge clk);
    sb.delete();

    // ---- reset during a port-1 store access ----
    do_access(mk(0, 1, DMOP_WORD, 32'h40, 32'hA5A5A5A5, 32'h0, 0), 32'h5000);
    wc = wr_cnt;
    p1_we = 1; p1_op = DMOP_WORD; p1_addr = 32'h40; p1_wdata = 32'h11111111; p1_pc = 32'h5004;
    p1_req = 1;
    @(negedge clk);
    chk("rstacc_gnt", {31'd0, p1_gnt}, 32'd1);
    reset = 1;
    p1_req = 0;
    #1;
    chk("rstacc_dm_we_gated", {31'd0, dm_we}, 32'd0);
    @(negedge clk);
    reset = 0;
    chk("rstacc_busy", {31'd0, busy}, 32'd0);
    chk("rstacc_rvalid", {31'd0, p1_rvalid}, 32'd0);
    @(negedge clk);
    chk("rstacc_rvalid2", {31'd0, p1_rvalid}, 32'd0);
    chk("rstacc_no_write", wr_cnt, wc);
    chk("rstacc_rdata", rdata, 32'd0);
    do_access(mk(0, 0, DMOP_WORD, 32'h40, 32'h0, 32'hA5A5A5A5, 0), 32'h5008);

    // ---- misaligned word store ----
`ifdef DM_ARB_ALIGN_CHK_EN
    mis = 1'b1;
`else
    mis = 1'b0;
`endif
    do_access(mk(1, 1, DMOP_WORD, 32'h42, 32'h0BADF00D, 32'h0, mis), 32'h6000);
    v = mk(0, 0, DMOP_WORD, 32'h40, 32'h0, mis ? 32'hA5A5A5A5 : 32'h0BADF00D, 0);
    do_access(v, 32'h6004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port data memory (word-addressed RAM, DMOp-encoded word/half/byte access, sub-word merge done inside the memory).
- Port 0 is the CPU load/store path; port 1 is a secondary master (DMA/debug loader).
- Serialises accesses into one memory cycle each, registers read data, and bounds port-1 starvation.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, data width.
MAX_WAIT, 4, consecutive port-1 losses before port 1 is force-granted; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
pN_req  in  1  port N (N=0,1) request; held until pN_gnt.
pN_we  in  1  port N store (1) / load (0).
pN_op  in  3  port N DMOp: 0 none, 1 word, 2 half, 3 byte.
pN_addr  in  ADDR_W  port N byte address.
pN_wdata  in  DATA_W  port N store data (low bytes for half/byte).
pN_pc  in  32  port N PC, forwarded for the store trace.
pN_gnt  out  1  one-cycle pulse: port N request captured.
pN_rvalid  out  1  one-cycle pulse: rdata/err valid for port N.
rdata  out  DATA_W  registered load result (shared bus).
err  out  1  misaligned access flag, valid with pN_rvalid.
busy  out  1  high when state != IDLE.
dm_addr  out  ADDR_W  memory address.
dm_wdata  out  DATA_W  memory write data.
dm_we  out  1  memory write enable.
dm_op  out  3  memory DMOp.
dm_pc  out  32  memory PC.
dm_rdata  in  DATA_W  memory combinational read data.

Behaviour:
- FSM: IDLE -> ACCESS -> IDLE. Peak rate one access per 2 cycles.
- IDLE, any req at posedge:
  - pick winner; latch we/op/addr/wdata/pc and winner id;
  - go to ACCESS; winner's pN_gnt high for the following cycle.
- Priority:
  - Port 0 wins unless wait_cnt == MAX_WAIT, then port 1 wins.
  - wait_cnt: 4-bit; +1 at each IDLE posedge where p1_req=1 and port 0 wins; cleared on port-1 grant or when p1_req=0 in IDLE; saturates at MAX_WAIT.
- ACCESS cycle:
  - dm_* driven from latched fields; dm_we = latched we & ~reset.
  - At its closing posedge: rdata <= dm_rdata (loads), rdata <= 0 (stores); winner's pN_rvalid high next cycle (overlaps next IDLE cycle); state <= IDLE.
- Outside ACCESS: dm_op=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_pc=0.
- req seen during ACCESS is ignored; requester holds req until gnt. A new request may be asserted in the cycle of its rvalid.
- Port with pN_op=0 and pN_req=1: granted, no write, rdata=0.
- Reset (synchronous):
  - State, wait_cnt, latches, rdata, err, all gnt/rvalid, busy -> 0.
  - Reset during ACCESS: access aborted, no write (dm_we gated), no rvalid.
- Without the optional feature, err is constant 0.

Optional Feature:
DM_ARB_ALIGN_CHK_EN
- Defined: in ACCESS, word with addr[1:0]!=0 or half with addr[0]!=0 forces dm_we=0 and dm_op=0; rvalid still pulses with err=1, rdata=0.
- Undefined: no check; address passed as-is; err tied 0.

Decomposition:
- Package dm_pkg: DMOp constants (DMOP_NONE=0, DMOP_WORD=1, DMOP_HALF=2, DMOP_BYTE=3); FSM state constants (ST_IDLE, ST_ACCESS).
- One sub-module, dm_arb_prio: combinational winner select plus wait_cnt register. Request latch and FSM live in the top.

Test Plan:
- Single port-0 store: p0 we=1, op=1, addr=0x10, wdata=0xDEADBEEF. Then p0_gnt at T+1, dm_we=1 at T+1, p0_rvalid at T+2; a later word load at 0x10 returns rdata=0xDEADBEEF.
- Simultaneous req, MAX_WAIT=4, both held continuously: grants go p0,p0,p0,p0,p1 (5th grant to port 1); wait_cnt returns to 0 after it.
- Byte load: word 0x80FF1234 stored at 0x20, then op=3 at addr 0x23. Then rdata=0xFFFFFF80 with p0_rvalid; half load at 0x22 gives 0xFFFF80FF.
- Reset in ACCESS cycle of p1 store to 0x40: no write occurs, no p1_rvalid, busy=0 the next cycle.
- DM_ARB_ALIGN_CHK_EN defined, word store at 0x42: dm_we stays 0, err=1 with rvalid, memory at 0x40 unchanged.
- Back-to-back p0 loads, req held: gnt pulses every 2 cycles; rvalid of load k coincides with IDLE cycle sampling load k+1.
